// File: rtl/sts_counter_bank.sv
// Bank of free-running 32-bit event counters with a coherent snapshot into a wide status word.
// A snapshot is taken on a gate-timer terminal count or on a manual request.
module sts_counter_bank #(
  parameter  int N_CNT     = 8,
  parameter  int CNT_WIDTH = 32,
  localparam int STS_WIDTH = (N_CNT + 1) * 32
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [N_CNT-1:0]     events,
  input  logic [31:0]          cfg_period,
  input  logic                 cfg_clear_on_snap,
  input  logic                 snap_req,
  input  logic                 clr,
  output logic [STS_WIDTH-1:0] sts_data,
  output logic                 snap_valid
);

  logic [CNT_WIDTH-1:0] r_acc [N_CNT];
  logic [31:0]          r_timer;
  logic                 r_ovf;
  logic [15:0]          r_seq;
  logic [STS_WIDTH-1:0] r_sts;
  logic                 r_snap_valid;

  logic [CNT_WIDTH-1:0] w_sum [N_CNT];
  logic [N_CNT-1:0]     w_wrap_vec;
  logic                 w_wrap;
  logic                 w_gate_fire;
  logic                 w_snap;

  always_comb begin
    for (int i = 0; i < N_CNT; i++) begin
      w_sum[i]      = r_acc[i] + {{(CNT_WIDTH-1){1'b0}}, events[i]};
      w_wrap_vec[i] = (&r_acc[i]) & events[i];
    end
    w_wrap = |w_wrap_vec;
    // ">=" lets a shortened period take effect at once instead of waiting for a wrap.
    w_gate_fire = (cfg_period != 32'd0) && (r_timer >= cfg_period - 32'd1);
    w_snap      = w_gate_fire | snap_req;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < N_CNT; i++) r_acc[i] <= '0;
      r_timer      <= '0;
      r_ovf        <= 1'b0;
      r_seq        <= '0;
      r_sts        <= '0;
      r_snap_valid <= 1'b0;
    end else begin
      if (clr || cfg_period == 32'd0 || w_gate_fire) r_timer <= '0;
      else                                           r_timer <= r_timer + 32'd1;

      for (int i = 0; i < N_CNT; i++) begin
        if (clr || (w_snap && cfg_clear_on_snap)) r_acc[i] <= '0;
        else                                      r_acc[i] <= w_sum[i];
      end

      if (clr || w_snap) r_ovf <= 1'b0;
      else if (w_wrap)   r_ovf <= 1'b1;

      r_snap_valid <= w_snap;
      // Snapshot is taken before clr applies, so a clr cycle still reports acc + events.
      if (w_snap) begin
        r_seq        <= r_seq + 16'd1;
        r_sts[31:0]  <= {r_seq + 16'd1, 15'd0, r_ovf | w_wrap};
        for (int i = 0; i < N_CNT; i++) r_sts[(i+1)*32 +: 32] <= w_sum[i];
      end
    end
  end

  // No back-pressure: snap_valid is a one-cycle notification and sts_data may be read at any time.
  assign sts_data   = r_sts;
  assign snap_valid = r_snap_valid;

endmodule

// File: tb/tb_sts_counter_bank.sv
// Self-checking bench for sts_counter_bank: table-driven periodic runs plus hand-written corner sequences.
// Expected snapshots go into a queue when stimulus is driven and are compared when snap_valid appears.
module tb_sts_counter_bank;

  localparam int N_CNT = 8;
  localparam int STS_W = (N_CNT + 1) * 32;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic [N_CNT-1:0] events = '0;
  logic [31:0]      cfg_period = '0;
  logic             cfg_clear_on_snap = 1'b0;
  logic             snap_req = 1'b0;
  logic             clr = 1'b0;
  logic [STS_W-1:0] sts_data;
  logic             snap_valid;

  sts_counter_bank #(.N_CNT(N_CNT)) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .events            (events),
    .cfg_period        (cfg_period),
    .cfg_clear_on_snap (cfg_clear_on_snap),
    .snap_req          (snap_req),
    .clr               (clr),
    .sts_data          (sts_data),
    .snap_valid        (snap_valid)
  );

  // clock / reset block
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // scoreboard: {idx[63:56], seq[55:40], ovf[32], word[31:0]}
  logic [63:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int snap_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int idx, input int seq, input bit ovf, input logic [31:0] word);
    logic [7:0]  i8;
    logic [15:0] s16;
    i8  = idx[7:0];
    s16 = seq[15:0];
    exp_q.push_back({i8, s16, 7'd0, ovf, word});
  endtask

  always @(negedge aclk) begin
    if (aresetn && snap_valid) begin
      logic [63:0] e;
      int idx;
      snap_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_snap", 64'(sts_data[31:0]), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e   = exp_q.pop_front();
        idx = int'(e[63:56]);
        check("snap_seq",     64'(sts_data[31:16]), 64'(e[55:40]));
        check("snap_ovf",     64'(sts_data[0]),     64'(e[32]));
        check("snap_w0_zero", 64'(sts_data[15:1]),  64'd0);
        check("snap_word",    64'(sts_data[idx*32 +: 32]), 64'(e[31:0]));
      end
    end
  end

  // driver tasks
  task automatic cyc();
    @(negedge aclk);
  endtask

  task automatic do_reset(input logic [31:0] period, input bit clear_on_snap);
    aresetn = 1'b0; events = '0; snap_req = 1'b0; clr = 1'b0;
    cfg_period = period; cfg_clear_on_snap = clear_on_snap;
    cyc(); cyc();
    check("rst_sts_zero", 64'(|sts_data), 64'd0);
    check("rst_valid",    64'(snap_valid), 64'd0);
    snap_cnt = 0;
    exp_q.delete();
    aresetn = 1'b1;
  endtask

  task automatic finish_section(input string name, input int exp_snaps);
    events = '0; snap_req = 1'b0; clr = 1'b0; cfg_period = '0;
    repeat (3) cyc();
    check({name, "_snap_count"}, 64'(snap_cnt), 64'(exp_snaps));
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  typedef struct {
    int period;
    int idx;
    bit clear_on_snap;
    int nsnap;
  } row_t;

  row_t rows[4];

  initial begin
    rows[0] = '{period: 10, idx: 0, clear_on_snap: 1'b1, nsnap: 3};
    rows[1] = '{period: 1,  idx: 3, clear_on_snap: 1'b1, nsnap: 4};
    rows[2] = '{period: 6,  idx: 7, clear_on_snap: 1'b0, nsnap: 3};
    rows[3] = '{period: 3,  idx: 5, clear_on_snap: 1'b0, nsnap: 2};

    // Periodic disabled: counting alone must never produce a snapshot.
    do_reset(32'd0, 1'b0);
    events = 8'h01;
    repeat (100) cyc();
    check("idle_sts_zero", 64'(|sts_data), 64'd0);
    finish_section("idle", 0);

    // Periodic gate, one event line held high per row.
    for (int r = 0; r < 4; r++) begin
      do_reset(32'(rows[r].period), rows[r].clear_on_snap);
      for (int k = 1; k <= rows[r].nsnap; k++)
        push_exp(rows[r].idx + 1, k, 1'b0,
                 rows[r].clear_on_snap ? 32'(rows[r].period) : 32'(k * rows[r].period));
      events = '0;
      events[rows[r].idx] = 1'b1;
      repeat (rows[r].period * rows[r].nsnap) cyc();
      finish_section("periodic", rows[r].nsnap);
    end

    // Manual snapshots, accumulators keep running.
    do_reset(32'd0, 1'b0);
    events = 8'h04;
    repeat (4) cyc();
    push_exp(3, 1, 1'b0, 32'd5);
    snap_req = 1'b1; cyc(); snap_req = 1'b0;
    repeat (2) cyc();
    events = '0;
    push_exp(3, 2, 1'b0, 32'd7);
    snap_req = 1'b1; cyc(); snap_req = 1'b0;
    finish_section("manual", 2);

    // Manual request coinciding with the gate terminal gives one snapshot.
    do_reset(32'd4, 1'b1);
    events = 8'h01;
    push_exp(1, 1, 1'b0, 32'd4);
    repeat (3) cyc();
    snap_req = 1'b1; cyc(); snap_req = 1'b0;
    events = '0; cfg_period = '0;
    cyc();
    push_exp(1, 2, 1'b0, 32'd0);
    snap_req = 1'b1; cyc(); snap_req = 1'b0;
    finish_section("coincide", 2);

    // Overflow: wrap before the snapshot, sticky clear, then wrap inside the snapshot cycle.
    do_reset(32'd0, 1'b0);
    dut.r_acc[1] = 32'hFFFF_FFFE;
    events = 8'h02;
    repeat (3) cyc();
    events = '0;
    push_exp(2, 1, 1'b1, 32'd1);
    snap_req = 1'b1; cyc();
    push_exp(2, 2, 1'b0, 32'd1);
    cyc(); snap_req = 1'b0;
    dut.r_acc[1] = 32'hFFFF_FFFF;
    events = 8'h02;
    push_exp(2, 3, 1'b1, 32'd0);
    snap_req = 1'b1; cyc(); snap_req = 1'b0;
    events = '0;
    finish_section("overflow", 3);

    // clr mid-window restarts the gate; then clr together with a manual snapshot.
    do_reset(32'd20, 1'b1);
    events = 8'h01;
    repeat (7) cyc();
    clr = 1'b1; cyc(); clr = 1'b0;
    check("clr_sts_held",  64'(|sts_data), 64'd0);
    check("clr_no_valid",  64'(snap_valid), 64'd0);
    push_exp(1, 1, 1'b0, 32'd20);
    repeat (20) cyc();
    cfg_period = '0; cfg_clear_on_snap = 1'b0;
    repeat (3) cyc();
    push_exp(1, 2, 1'b0, 32'd4);
    clr = 1'b1; snap_req = 1'b1; cyc(); clr = 1'b0; snap_req = 1'b0;
    events = '0;
    push_exp(1, 3, 1'b0, 32'd0);
    snap_req = 1'b1; cyc(); snap_req = 1'b0;
    finish_section("clr", 3);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
